// File: rtl/shift_rows_serial.sv
// Byte-serial AES ShiftRows with a ping-pong pair of 16-byte banks, column-major in and out.
// Define SHIFT_ROWS_INV_EN to add the inv port and a per-bank InvShiftRows mode bit.
module shift_rows_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
`ifdef SHIFT_ROWS_INV_EN
  input  logic       inv,
`endif
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);

  logic            wb_reg;
  logic            rb_reg;
  logic [3:0]      wc_reg;
  logic [3:0]      rc_reg;
  logic [1:0]      full_reg;
  logic [1:0][7:0] rd_byte;
  logic            in_fire;
  logic            out_fire;
  logic            wr_done;
  logic            rd_done;
  logic [1:0]      row;
  logic [1:0]      col;
  logic [1:0]      src_col;
  logic [3:0]      src_idx;

  assign in_ready  = !full_reg[wb_reg];
  assign out_valid = full_reg[rb_reg];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wr_done   = in_fire && (wc_reg == 4'd15);
  assign rd_done   = out_fire && (rc_reg == 4'd15);

  // Output byte k sits at row k%4, column k/4; the column shift wraps naturally in 2 bits.
  assign row = rc_reg[1:0];
  assign col = rc_reg[3:2];

`ifdef SHIFT_ROWS_INV_EN
  logic [1:0] mode_reg;
  assign src_col = mode_reg[rb_reg] ? (col - row) : (col + row);
`else
  assign src_col = col + row;
`endif

  assign src_idx  = {src_col, row};
  assign out_byte = out_valid ? rd_byte[rb_reg] : 8'h00;
  assign out_last = out_valid && (rc_reg == 4'd15);
  assign busy     = (|full_reg) || (wc_reg != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_reg <= 1'b0;
      rb_reg <= 1'b0;
      wc_reg <= 4'd0;
      rc_reg <= 4'd0;
    end else begin
      if (in_fire) begin
        wc_reg <= wc_reg + 4'd1;
        if (wr_done) wb_reg <= !wb_reg;
      end
      if (out_fire) begin
        rc_reg <= rc_reg + 4'd1;
        if (rd_done) rb_reg <= !rb_reg;
      end
    end
  end

  // Each bank owns its storage and full flag; a fill on one bank and a drain on the
  // other in the same edge land independently, which keeps streaming at one byte/cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [7:0] mem_reg [16];
    logic       full_bank_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) mem_reg[i] <= 8'h00;
      end else if (in_fire && (wb_reg == 1'(gi))) begin
        mem_reg[wc_reg] <= in_byte;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        full_bank_reg <= 1'b0;
      end else if (wr_done && (wb_reg == 1'(gi))) begin
        full_bank_reg <= 1'b1;
      end else if (rd_done && (rb_reg == 1'(gi))) begin
        full_bank_reg <= 1'b0;
      end
    end

`ifdef SHIFT_ROWS_INV_EN
    logic mode_bank_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_bank_reg <= 1'b0;
      end else if (in_fire && (wb_reg == 1'(gi)) && (wc_reg == 4'd0)) begin
        mode_bank_reg <= inv;
      end
    end
    assign mode_reg[gi] = mode_bank_reg;
`endif

    assign full_reg[gi] = full_bank_reg;
    assign rd_byte[gi]  = mem_reg[src_idx];
  end

endmodule

// File: tb/tb_shift_rows_serial.sv
// Scoreboard bench for shift_rows_serial: random blocks, matrix-level ShiftRows reference model.
`timescale 1ns/1ps
module tb_shift_rows_serial;
  typedef logic [7:0] blk_t [16];

`ifdef SHIFT_ROWS_INV_EN
  localparam bit INV_EN = 1'b1;
  logic inv = 1'b0;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  int out_idx = 0;
  int cyc = 0;
  int out_cnt = 0;
  int first_out = -1;
  int last_out = -1;
  int inrdy_low = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  shift_rows_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef SHIFT_ROWS_INV_EN
    .inv       (inv),
`endif
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: load the 4x4 state column-major, rotate row r left by r (right by r for
  // the inverse), then read the result back column-major.
  function automatic void model(input blk_t blk, input bit mode, output blk_t o);
    logic [7:0] st [4][4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = blk[4*c + r];
    for (int k = 0; k < 16; k++) begin
      int r = k % 4;
      int c = k / 4;
      int sc = mode ? (c - r + 4) % 4 : (c + r) % 4;
      o[k] = st[r][sc];
    end
  endfunction

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: actual=%0h required=none", out_byte);
        end else begin
          e = exp_q.pop_front();
          check("out_byte", {24'd0, out_byte}, {24'd0, e});
          check("out_last", {31'd0, out_last}, {31'd0, (out_idx % 16) == 15});
        end
        out_idx++;
        out_cnt++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end else if (!out_valid) begin
        check("idle_out_byte", {24'd0, out_byte}, 32'd0);
      end
      if (mon_en && !in_ready) inrdy_low++;
    end
  end

  task automatic put_byte(input logic [7:0] b);
    int t = 0;
    bit hs;
    in_valid = 1'b1;
    in_byte = b;
    do begin
      hs = in_ready;
      @(posedge clk); #1;
      t++;
    end while (!hs && t < 2000);
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL in_timeout: actual=in_ready_low required=handshake");
    end
  endtask

  task automatic send_block(input blk_t blk, input bit mode, input bit gap);
    blk_t o;
    for (int i = 0; i < 16; i++) begin
`ifdef SHIFT_ROWS_INV_EN
      inv = (i == 0) ? mode : 1'($urandom);
`endif
      put_byte(blk[i]);
      if (gap && i < 15 && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    model(blk, mode, o);
    for (int k = 0; k < 16; k++) exp_q.push_back(o[k]);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: actual=%0d_left required=0", exp_q.size());
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    check({tag, "_out_byte"}, {24'd0, out_byte}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t b, o, fwd_exp, inv_exp;
    int bad;
    fwd_exp = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    inv_exp = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    for (int i = 0; i < 16; i++) b[i] = 8'(i);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed forward block with latency check
    model(b, 1'b0, o);
    for (int k = 0; k < 16; k++) check("ref_fwd_table", {24'd0, o[k]}, {24'd0, fwd_exp[k]});
    out_ready = 1'b1;
    send_block(b, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    check("latency_byte", {24'd0, out_byte}, 32'h00);
    wait_drain();
    check("idle_busy", {31'd0, busy}, 32'd0);

`ifdef SHIFT_ROWS_INV_EN
    model(b, 1'b1, o);
    for (int k = 0; k < 16; k++) check("ref_inv_table", {24'd0, o[k]}, {24'd0, inv_exp[k]});
    send_block(b, 1'b1, 1'b0);
    in_valid = 1'b0;
    wait_drain();
`endif

    // Backpressure: two blocks buffered (forward then inverse if available), third stalls
    out_ready = 1'b0;
    send_block(b, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) o[i] = 8'($urandom);
    send_block(o, INV_EN, 1'b0);
    in_valid = 1'b1;
    in_byte = 8'($urandom);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (in_ready || out_byte !== 8'h00 || out_last || !out_valid) bad++;
    end
    check("bp_hold", bad, 0);
    check("bp_busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    out_cnt = 0;
    first_out = -1;
    out_ready = 1'b1;
    wait_drain();
    check("bp_count", out_cnt, 32);
    check("bp_gapless", last_out - first_out, 31);
    check("bp_busy_after", {31'd0, busy}, 32'd0);

    // Streaming: four back-to-back blocks
    out_cnt = 0;
    first_out = -1;
    inrdy_low = 0;
    mon_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) o[i] = 8'($urandom);
      send_block(o, INV_EN && ($urandom_range(1) == 1), 1'b0);
    end
    in_valid = 1'b0;
    mon_en = 1'b0;
    wait_drain();
    check("stream_count", out_cnt, 64);
    check("stream_gapless", last_out - first_out, 63);
    check("stream_in_ready", inrdy_low, 0);

    // Reset mid-block with a buffered block pending
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) o[i] = 8'($urandom);
    send_block(o, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) put_byte(8'($urandom));
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outs("midrst");
    exp_q.delete();
    out_idx = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_block(b, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_drain();

    // Random traffic with input gaps and random backpressure
    fork
      begin
        for (int n = 0; n < 6; n++) begin
          for (int i = 0; i < 16; i++) o[i] = 8'($urandom);
          send_block(o, INV_EN && ($urandom_range(1) == 1), 1'b1);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (300) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_rows_serial.md
SHIFT_ROWS_SERIAL -- requirements
Module: shift_rows_serial

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 in_byte  input  8  state byte in; block order is column-major, byte i = row i%4, column i/4.
REQ-004 in_valid  input  1  in_byte valid.
REQ-005 in_ready  output  1  block can accept in_byte this cycle.
REQ-006 out_byte  output  8  shifted state byte out, column-major order; feeds mixColumns in_byte.
REQ-007 out_valid  output  1  out_byte valid.
REQ-008 out_ready  input  1  downstream accepts out_byte.
REQ-009 out_last  output  1  high with out_valid on the 16th output byte of a block.
REQ-010 busy  output  1  high when any bank is non-empty or a block is partly written.

Function
REQ-011 The block SHALL hold two 16-byte banks (ping-pong), a write bank pointer wb, a read bank pointer rb, 4-bit write count wc, 4-bit read count rc, and a full flag per bank.
REQ-012 An input handshake is in_valid && in_ready; an output handshake is out_valid && out_ready.
REQ-013 in_ready SHALL equal !full[wb]; out_valid SHALL equal full[rb]; both are driven from registers only.
REQ-014 On an input handshake, in_byte SHALL be written to bank[wb][wc] and wc SHALL increment, wrapping 15->0.
REQ-015 On the handshake with wc==15, full[wb] SHALL set and wb SHALL toggle in the same edge.
REQ-016 Forward mapping: output byte k (r=k%4, c=k/4) SHALL be bank[rb][4*((c+r) mod 4)+r].
REQ-017 On an output handshake, rc SHALL increment, wrapping 15->0; when rc==15, full[rb] SHALL clear and rb SHALL toggle.
REQ-018 out_last SHALL be high iff out_valid && rc==15.
REQ-019 out_byte and out_last SHALL hold stable while out_valid && !out_ready.
REQ-020 Latency: the first output byte SHALL be valid on the cycle after the 16th input handshake of a block, if the read bank is otherwise free.
REQ-021 A full flag set on one bank and a clear on the other in the same edge SHALL both take effect. Sustained throughput SHALL be one byte per cycle.
REQ-022 With both banks full, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-023 When out_valid is 0, out_byte SHALL be 8'h00.
REQ-024 busy SHALL equal full[0] || full[1] || (wc != 0).

Reset
REQ-025 While rst_n is 0, the block SHALL clear wb, rb, wc, rc, both full flags, and all bank bytes to 0, asynchronously.
REQ-026 In reset, outputs SHALL be in_ready=1, out_valid=0, out_last=0, out_byte=8'h00, busy=0.
REQ-027 Reset asserted mid-block SHALL discard all partial and buffered data. The first handshake after release SHALL be byte 0 of a new block.

Configuration
REQ-028 Macro SHIFT_ROWS_INV_EN defined: the block SHALL add port inv (input, 1 bit) and a per-bank mode bit.
REQ-029 With SHIFT_ROWS_INV_EN defined, inv SHALL be sampled into the mode bit of bank wb on the input handshake with wc==0, and ignored otherwise.
REQ-030 With SHIFT_ROWS_INV_EN defined, a bank whose mode bit is 1 SHALL output bank[rb][4*((c-r) mod 4)+r] (InvShiftRows).
REQ-031 Macro undefined: there SHALL be no inv port, no mode bits, and forward mapping only.

Verification
REQ-032 Forward: input bytes 00..0F, out_ready=1 -> output 00,05,0A,0F,04,09,0E,03,08,0D,02,07,0C,01,06,0B; first byte on the cycle after the 16th input; out_last on 0B.
REQ-033 Inverse (macro on, inv=1 at byte 0): input 00..0F -> output 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03.
REQ-034 Backpressure: out_ready=0 with 48 bytes offered -> in_ready falls after 32 handshakes and out_byte holds 00. Releasing out_ready then drains both blocks in order with no gaps.
REQ-035 Streaming: 4 back-to-back blocks with in_valid and out_ready held high -> 64 outputs in 64 consecutive cycles and in_ready never low.
REQ-036 Reset mid-block: rst_n low after 7 inputs -> outputs immediately at reset values. A fresh block 00..0F then yields the REQ-032 sequence.
REQ-037 Mixed modes (macro on): block A with inv=0 and block B with inv=1 buffered together -> each block drains with its own mapping.
